even_parity_serial_tx: RTL and testbench
========================================

EVEN_PARITY_SERIAL_TX -- requirements
Module: even_parity_serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 4, payload width in bits (legal 1..16).
REQ-002 SHALL have parameter BAUD_DIV, default 1, clocks per serial bit (legal 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  DATA_W  payload word.
REQ-006 SHALL have port in_valid  input  1  payload offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a word.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port par_out  output  1  even-parity bit of the last accepted word (same p as a 4-bit even parity checker expects).
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-012 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, capturing in_data and its parity into registers.
REQ-013 SHALL drive in_ready=1 only in state IDLE; in_valid while not IDLE is ignored, with no loss of the frame in flight.
REQ-014 SHALL compute par_out = XOR of all accepted bits, so that data plus parity has an even count of ones; par_out holds until the next accept.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA, DATA->PARITY after DATA_W bits, PARITY->STOP, STOP->IDLE, each bit lasting exactly BAUD_DIV cycles.
REQ-016 SHALL drive tx: IDLE=1, START=0, DATA=captured bits LSB first, PARITY=par_out, STOP=1.
REQ-017 SHALL begin START in the cycle after the accept edge; frame length is (DATA_W+3)*BAUD_DIV cycles.
REQ-018 SHALL assert busy in every non-IDLE state.
REQ-019 SHALL pulse frame_done high during the final cycle of STOP only.
REQ-020 SHALL allow back-to-back frames: in_ready is high in the first IDLE cycle after STOP, giving a minimum one-cycle idle gap.
REQ-021 SHALL ignore in_data changes after accept.
REQ-022 SHALL use a bit counter wide enough for DATA_W and a baud counter wide enough for BAUD_DIV-1, with no wrap within a frame.

Reset
REQ-023 SHALL, on a rst-high edge, force state=IDLE, tx=1, in_ready=1 (after the rst-high cycle), busy=0, frame_done=0, par_out=0, and clear both counters and the data register.
REQ-024 SHALL abandon any in-flight frame on reset mid-frame; tx returns high on the next edge, and no frame_done pulse occurs.
REQ-025 SHALL hold in_ready=0 while rst=1, so that no accept is possible during reset.

Configuration
REQ-026 SHALL support macro PARITY_ERR_INJECT_EN. When defined, it adds input port err_inject (1 bit); if err_inject=1 at accept, the transmitted parity bit and par_out are inverted for that frame.
REQ-027 SHALL, when PARITY_ERR_INJECT_EN is undefined, have no err_inject port and always transmit correct even parity.

Structure
REQ-028 SHALL place the state encoding typedef (5 states) and default DATA_W/BAUD_DIV constants in shared package even_parity_pkg.
REQ-029 SHALL instantiate one sub-module even_parity_gen (parameterised XOR-reduce, DATA_W in, 1-bit parity out), reusable by the checker side.

Verification
REQ-030 SHALL cover single frame: DATA_W=4, BAUD_DIV=1, in_data=4'b1011 -> par_out=1, tx over 7 cycles = 0,1,1,0,1,1,1, frame_done on cycle 7.
REQ-031 SHALL cover sweep: all 16 values of 4-bit in_data -> par_out matches the even-parity table (0000->0, 0001->1, 1111->0); a 4-bit even parity checker fed {captured data, par_out} reports error=0.
REQ-032 SHALL cover baud: BAUD_DIV=3, in_data=4'b0001 -> each bit held 3 cycles, 21-cycle frame, busy high for 21 cycles.
REQ-033 SHALL cover backpressure: in_valid held high with data changing mid-frame -> in_ready=0 while busy, second word accepted in the first IDLE cycle, the first frame is unchanged.
REQ-034 SHALL cover reset mid-frame: rst asserted in DATA cycle 2 -> tx=1 and busy=0 next edge, no frame_done, the next frame is correct.
REQ-035 SHALL cover error injection: with PARITY_ERR_INJECT_EN, in_data=4'b0011 and err_inject=1 -> parity bit transmitted as 1 and the checker reports error=1.

Source files
------------

// File: rtl/even_parity_pkg.sv
// Shared types and defaults for the even-parity serial transmitter and its checker-side helpers.
package even_parity_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int BAUD_DIV_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/even_parity_gen.sv
// Even-parity generator: XOR-reduce of a W-bit word, shared by transmitter and checker.
module even_parity_gen #(
  parameter int W = 4
) (
  input  logic [W-1:0] data_i,
  output logic         parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Serial framer: START, DATA_W data bits LSB first, even parity, STOP; each bit BAUD_DIV clocks.
// Optional macro PARITY_ERR_INJECT_EN adds err_inject to invert the parity of the accepted frame.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              par_out,
  output logic              busy,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              frame_done
);

  localparam int BIT_W  = cnt_w(DATA_W);
  localparam int BAUD_W = cnt_w(BAUD_DIV);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'((BAUD_DIV > 1) ? BAUD_DIV - 2 : 0);

  state_e              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [BAUD_W-1:0]   baud_cnt_q;
  logic                tx_q;
  logic                par_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                par_gen;
  logic                par_d;
  logic                inject;

`ifdef PARITY_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  even_parity_gen #(.W(DATA_W)) u_par_gen (
    .data_i   (in_data),
    .parity_o (par_gen)
  );

  assign par_d      = par_gen ^ inject;
  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign tx         = tx_q;
  assign par_out    = par_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // data_q is a shift register: the next data bit to send always sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      baud_cnt_q   <= '0;
      tx_q         <= 1'b1;
      par_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (in_valid && in_ready) begin
          state_q    <= ST_START;
          data_q     <= in_data;
          par_q      <= par_d;
          bit_cnt_q  <= '0;
          baud_cnt_q <= '0;
          tx_q       <= 1'b0;
          busy_q     <= 1'b1;
        end
      end else if (baud_cnt_q != BAUD_LAST) begin
        baud_cnt_q   <= baud_cnt_q + 1'b1;
        frame_done_q <= (state_q == ST_STOP) && (baud_cnt_q == BAUD_PRE);
      end else begin
        baud_cnt_q <= '0;
        case (state_q)
          ST_START: begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
            tx_q      <= data_q[0];
            data_q    <= data_q >> 1;
          end
          ST_DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= ST_PARITY;
              tx_q    <= par_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= data_q[0];
              data_q    <= data_q >> 1;
            end
          end
          ST_PARITY: begin
            state_q      <= ST_STOP;
            tx_q         <= 1'b1;
            frame_done_q <= (BAUD_DIV == 1);
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench: parity table sweep, random frames against a bit-list model, baud, backpressure, reset.
module tb_even_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready, tx, par_out, busy, frame_done;
  logic [3:0] in3_data;
  logic       in3_valid;
  logic       in3_ready, tx3, par3, busy3, fd3;
`ifdef PARITY_ERR_INJECT_EN
  logic       err_inject = 1'b0;
  logic       err_inject3 = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  even_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .par_out(par_out), .busy(busy),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .frame_done(frame_done));

  even_parity_serial_tx #(.DATA_W(4), .BAUD_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in3_data), .in_valid(in3_valid), .in_ready(in3_ready),
    .tx(tx3), .par_out(par3), .busy(busy3),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(err_inject3),
`endif
    .frame_done(fd3));

  typedef struct packed {
    logic [3:0] d;
    logic       p;
  } vec_t;
  vec_t tbl [16];

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Line image of a frame: start, data LSB first, parity, stop, each held b clocks.
  task automatic mk_frame(input logic [3:0] d, input bit p, input int b);
    bit bits [7];
    exp_q.delete();
    bits[0] = 1'b0;
    for (int i = 0; i < 4; i++) bits[i+1] = d[i];
    bits[5] = p;
    bits[6] = 1'b1;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < b; j++) exp_q.push_back(bits[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    cmp("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Sends one word on dut and checks every cycle of its frame; returns at the first idle cycle.
  task automatic run_frame(input logic [3:0] d, input bit hold, input bit inj, input string nm);
    bit p;
    p = bit'($countones(d) % 2) ^ inj;
    mk_frame(d, p, 1);
    wait_ready();
    in_data  = d;
    in_valid = 1'b1;
`ifdef PARITY_ERR_INJECT_EN
    err_inject = inj;
`endif
    tick();
    if (!hold) in_valid = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    for (int k = 0; k < 7; k++) begin
      if (hold) in_data = 4'($urandom);
      cmp($sformatf("%s tx[%0d]", nm, k), {31'd0, tx}, {31'd0, exp_q[k]});
      cmp($sformatf("%s busy[%0d]", nm, k), {31'd0, busy}, 32'd1);
      cmp($sformatf("%s rdy[%0d]", nm, k), {31'd0, in_ready}, 32'd0);
      cmp($sformatf("%s done[%0d]", nm, k), {31'd0, frame_done}, {31'd0, k == 6});
      if (k < 6) tick();
    end
    tick();
    cmp({nm, " idle_busy"}, {31'd0, busy}, 32'd0);
    cmp({nm, " idle_rdy"}, {31'd0, in_ready}, 32'd1);
    cmp({nm, " idle_tx"}, {31'd0, tx}, 32'd1);
    cmp({nm, " par_out"}, {31'd0, par_out}, {31'd0, p});
    cmp({nm, " chk_err"}, {31'd0, ^{d, par_out}}, {31'd0, inj});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{4'b0000, 1'b0}; tbl[1]  = '{4'b0001, 1'b1};
    tbl[2]  = '{4'b0010, 1'b1}; tbl[3]  = '{4'b0011, 1'b0};
    tbl[4]  = '{4'b0100, 1'b1}; tbl[5]  = '{4'b0101, 1'b0};
    tbl[6]  = '{4'b0110, 1'b0}; tbl[7]  = '{4'b0111, 1'b1};
    tbl[8]  = '{4'b1000, 1'b1}; tbl[9]  = '{4'b1001, 1'b0};
    tbl[10] = '{4'b1010, 1'b0}; tbl[11] = '{4'b1011, 1'b1};
    tbl[12] = '{4'b1100, 1'b0}; tbl[13] = '{4'b1101, 1'b1};
    tbl[14] = '{4'b1110, 1'b1}; tbl[15] = '{4'b1111, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in3_valid = 1'b0; in3_data = '0;
    tick(); tick();
    cmp("rst tx", {31'd0, tx}, 32'd1);
    cmp("rst busy", {31'd0, busy}, 32'd0);
    cmp("rst done", {31'd0, frame_done}, 32'd0);
    cmp("rst par", {31'd0, par_out}, 32'd0);
    cmp("rst rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    cmp("post_rst rdy", {31'd0, in_ready}, 32'd1);

    run_frame(4'b1011, 1'b0, 1'b0, "single");

    for (int i = 0; i < 16; i++) begin
      run_frame(tbl[i].d, 1'b0, 1'b0, $sformatf("sweep%0d", i));
      cmp($sformatf("table par %0d", i), {31'd0, par_out}, {31'd0, tbl[i].p});
    end

    // Baud divider on the second instance: 0001 -> 21-cycle frame.
    mk_frame(4'b0001, 1'b1, 3);
    in3_data = 4'b0001; in3_valid = 1'b1;
    tick();
    in3_valid = 1'b0;
    in3_data  = 4'b1110;
    for (int k = 0; k < 21; k++) begin
      cmp($sformatf("baud tx[%0d]", k), {31'd0, tx3}, {31'd0, exp_q[k]});
      cmp($sformatf("baud busy[%0d]", k), {31'd0, busy3}, 32'd1);
      cmp($sformatf("baud done[%0d]", k), {31'd0, fd3}, {31'd0, k == 20});
      tick();
    end
    cmp("baud idle busy", {31'd0, busy3}, 32'd0);
    cmp("baud idle rdy", {31'd0, in3_ready}, 32'd1);
    cmp("baud par", {31'd0, par3}, 32'd1);

    // Backpressure: in_valid held, data churning mid-frame, second word back-to-back.
    run_frame(4'b0110, 1'b1, 1'b0, "bp_first");
    run_frame(4'b1001, 1'b0, 1'b0, "bp_second");

    // Reset in the second DATA cycle.
    in_data = 4'b1011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    cmp("mid busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    cmp("mid tx", {31'd0, tx}, 32'd1);
    cmp("mid busy", {31'd0, busy}, 32'd0);
    cmp("mid rdy_in_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cmp($sformatf("mid no_done[%0d]", k), {31'd0, frame_done}, 32'd0);
      cmp($sformatf("mid tx_idle[%0d]", k), {31'd0, tx}, 32'd1);
      tick();
    end
    run_frame(4'b0101, 1'b0, 1'b0, "after_rst");

`ifdef PARITY_ERR_INJECT_EN
    run_frame(4'b0011, 1'b0, 1'b1, "inject");
    run_frame(4'b0011, 1'b0, 1'b0, "no_inject");
`endif

    for (int r = 0; r < 25; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_frame(4'($urandom), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
